// File: rtl/erasable_ram_ctrl_if.sv
// Request/response bus between the erasable-memory interface and the RAM sequencer.
// The requester drives req/we/be/addr/wdata; the sequencer answers with busy/done/rdata.
interface erasable_ram_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  be;
  logic [10:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/erasable_ram_ctrl.sv
// Strobe sequencer for the asynchronous 2048x16 erasable RAM.
// One request at a time is turned into a write (setup / pulse / hold) or a read
// (E_ and G_ low, capture on exit), each followed by a one-cycle RECOVER.
// Every RAM pin comes straight from a flop, so the strobes are glitch-free and
// all of them change on the acceptance edge itself.
module erasable_ram_ctrl #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int READ_CYC  = 2
) (
  input  logic               SIM_CLK,
  input  logic               SIM_RST,
  erasable_ram_ctrl_if.slave bus,
  output logic               E_,
  output logic               W_,
  output logic               G_,
  output logic               UB_,
  output logic               LB_,
  output logic [15:0]        A,
  inout  wire  [15:0]        DQ
);

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || READ_CYC < 1) begin : g_param_check
    $error("erasable_ram_ctrl: SETUP_CYC, PULSE_CYC and READ_CYC must all be >= 1");
  end

  // The per-state counter only has to reach (longest phase - 1).
  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                           ? ((SETUP_CYC > READ_CYC) ? SETUP_CYC : READ_CYC)
                           : ((PULSE_CYC > READ_CYC) ? PULSE_CYC : READ_CYC);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_SETUP = 3'd1,
    W_PULSE = 3'd2,
    W_HOLD  = 3'd3,
    R_READ  = 3'd4,
    RECOVER = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic             accept;
  logic [1:0]       be_q;
  logic [1:0]       be_nxt;
  logic [15:0]      wdata_q;
  logic [15:0]      rdata_q;

  logic             e_nxt;
  logic             w_nxt;
  logic             g_nxt;
  logic             ub_nxt;
  logic             lb_nxt;
  logic             oe_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  logic             dq_oe;
  logic             busy_q;
  logic             done_q;

  // A request is taken only while idle; anything arriving while busy is dropped.
  assign accept = bus.req && (state == IDLE);

  // Byte enables seen by the strobe logic: the incoming ones on the acceptance
  // edge, the latched ones for the rest of the sequence.
  assign be_nxt = accept ? bus.be : be_q;

  // State register and per-state cycle counter.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: each timed phase leaves when its counter reaches the last cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) state_nxt = bus.we ? W_SETUP : R_READ;
      end
      W_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = W_PULSE;
          cnt_nxt   = '0;
        end
      end
      W_PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_nxt = W_HOLD;
          cnt_nxt   = '0;
        end
      end
      W_HOLD: begin
        state_nxt = RECOVER;
        cnt_nxt   = '0;
      end
      R_READ: begin
        if (cnt == READ_LAST) begin
          state_nxt = RECOVER;
          cnt_nxt   = '0;
        end
      end
      RECOVER: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Strobe decode from the upcoming state; W_ low only in W_PULSE and G_ low only
  // in R_READ, so the two can never be low together.
  always_comb begin
    e_nxt    = 1'b1;
    w_nxt    = 1'b1;
    g_nxt    = 1'b1;
    ub_nxt   = 1'b1;
    lb_nxt   = 1'b1;
    oe_nxt   = 1'b0;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == RECOVER);
    unique case (state_nxt)
      W_SETUP, W_HOLD: begin
        e_nxt  = 1'b0;
        ub_nxt = ~be_nxt[1];
        lb_nxt = ~be_nxt[0];
        oe_nxt = 1'b1;
      end
      W_PULSE: begin
        e_nxt  = 1'b0;
        w_nxt  = 1'b0;
        ub_nxt = ~be_nxt[1];
        lb_nxt = ~be_nxt[0];
        oe_nxt = 1'b1;
      end
      R_READ: begin
        e_nxt  = 1'b0;
        g_nxt  = 1'b0;
        ub_nxt = ~be_nxt[1];
        lb_nxt = ~be_nxt[0];
      end
      default: begin
        e_nxt = 1'b1;
      end
    endcase
  end

  // Registered RAM strobes and status; reset releases everything immediately.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      E_     <= 1'b1;
      W_     <= 1'b1;
      G_     <= 1'b1;
      UB_    <= 1'b1;
      LB_    <= 1'b1;
      dq_oe  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      E_     <= e_nxt;
      W_     <= w_nxt;
      G_     <= g_nxt;
      UB_    <= ub_nxt;
      LB_    <= lb_nxt;
      dq_oe  <= oe_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  // Address and byte enables latched at acceptance and held through the sequence.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      A    <= '0;
      be_q <= '0;
    end else if (accept) begin
      A    <= {5'b00000, bus.addr};
      be_q <= bus.be;
    end
  end

  // Write data latch; only observable while dq_oe is set, so it needs no reset.
  always_ff @(posedge SIM_CLK) begin
    if (accept) wdata_q <= bus.wdata;
  end

  // Read data captured on the edge that leaves R_READ; reset discards it.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      rdata_q <= '0;
    end else if (state == R_READ && cnt == READ_LAST) begin
      rdata_q <= DQ;
    end
  end

  assign DQ        = dq_oe ? wdata_q : 'z;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_erasable_ram_ctrl.sv
// Bench for erasable_ram_ctrl: a default-timed instance and a slow-setup/long-read
// instance, each attached to a behavioural asynchronous 2048x16 RAM.
module tb_erasable_ram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  erasable_ram_ctrl_if bus0();
  erasable_ram_ctrl_if bus1();

  logic        E0_, W0_, G0_, UB0_, LB0_;
  logic [15:0] A0;
  wire  [15:0] DQ0;
  logic        E1_, W1_, G1_, UB1_, LB1_;
  logic [15:0] A1;
  wire  [15:0] DQ1;

  erasable_ram_ctrl dut0 (
    .SIM_CLK(clk), .SIM_RST(rst), .bus(bus0),
    .E_(E0_), .W_(W0_), .G_(G0_), .UB_(UB0_), .LB_(LB0_), .A(A0), .DQ(DQ0)
  );

  erasable_ram_ctrl #(.SETUP_CYC(3), .PULSE_CYC(1), .READ_CYC(4)) dut1 (
    .SIM_CLK(clk), .SIM_RST(rst), .bus(bus1),
    .E_(E1_), .W_(W1_), .G_(G1_), .UB_(UB1_), .LB_(LB1_), .A(A1), .DQ(DQ1)
  );

  // Behavioural RAMs: level-sensitive writes, read drive while E_/G_ low and W_ high.
  logic [15:0] mem0 [2048];
  logic [15:0] mem1 [2048];

  assign DQ0 = (!E0_ && !G0_ && W0_) ? mem0[A0[10:0]] : 'z;
  assign DQ1 = (!E1_ && !G1_ && W1_) ? mem1[A1[10:0]] : 'z;
  pullup (DQ0);
  pullup (DQ1);

  always @(W0_ or E0_ or UB0_ or LB0_ or A0 or DQ0) begin
    if (!W0_ && !E0_) begin
      if (!UB0_) mem0[A0[10:0]][15:8] = DQ0[15:8];
      if (!LB0_) mem0[A0[10:0]][7:0]  = DQ0[7:0];
    end
  end

  always @(W1_ or E1_ or UB1_ or LB1_ or A1 or DQ1) begin
    if (!W1_ && !E1_) begin
      if (!UB1_) mem1[A1[10:0]][15:8] = DQ1[15:8];
      if (!LB1_) mem1[A1[10:0]][7:0]  = DQ1[7:0];
    end
  end

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;

  // Counts any cycle where either controller has G_ and W_ low together.
  always @(negedge clk) begin
    if ((!W0_ && !G0_) || (!W1_ && !G1_)) overlap++;
  end

  typedef struct {
    int          lat;
    int          wlow;
    logic [15:0] data;
    bit          chk_data;
  } exp_t;

  exp_t sb[$];

  task automatic drive(input int d, input logic r, input logic w, input logic [1:0] b,
                       input logic [10:0] a, input logic [15:0] wd);
    if (d == 0) begin
      bus0.req = r; bus0.we = w; bus0.be = b; bus0.addr = a; bus0.wdata = wd;
    end else begin
      bus1.req = r; bus1.we = w; bus1.be = b; bus1.addr = a; bus1.wdata = wd;
    end
  endtask

  // Issues one request from an idle controller and reports the done cycle
  // (counted from the acceptance edge), W_-low cycles and rdata at done.
  // lat stays 0 if done never arrives within the budget.
  task automatic run_op(input int d, input logic w, input logic [1:0] b,
                        input logic [10:0] a, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd, output int wl);
    lat = 0;
    wl  = 0;
    rd  = '0;
    @(negedge clk);
    drive(d, 1'b1, w, b, a, wd);
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) drive(d, 1'b0, w, b, a, wd);
      if ((d == 0) ? !W0_ : !W1_) wl++;
      if ((d == 0) ? bus0.done : bus1.done) begin
        lat = n;
        rd  = (d == 0) ? bus0.rdata : bus1.rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 2'b00, 11'd0, 16'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 11'd0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({E0_, W0_, G0_, UB0_, LB0_} !== 5'b11111)
      begin failures++; $display("FAIL reset_strobes got=%b exp=11111", {E0_, W0_, G0_, UB0_, LB0_}); end
    checks++;
    if (A0 !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", A0); end
    checks++;
    if (DQ0 !== 16'hFFFF) begin failures++; $display("FAIL reset_dq_released got=%h exp=FFFF(pulled)", DQ0); end
    checks++;
    if ({bus0.busy, bus0.done} !== 2'b00)
      begin failures++; $display("FAIL reset_busy_done got=%b exp=00", {bus0.busy, bus0.done}); end
    checks++;
    if (bus0.rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", bus0.rdata); end
    rst = 1'b0;
  endtask

  task automatic test_untouched();
    exp_t e; int lat, wl; logic [15:0] rd;
    sb.push_back('{3, 0, 16'o40000, 1'b1});
    run_op(0, 1'b0, 2'b11, 11'o3777, 16'h0, lat, rd, wl);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL untouched_latency got=%0d exp=%0d", lat, e.lat); end
    checks++;
    if (rd !== e.data) begin failures++; $display("FAIL untouched_rdata got=%o exp=%o", rd, e.data); end
  endtask

  task automatic test_write_read();
    exp_t e; int lat, wl; logic [15:0] rd;
    sb.push_back('{5, 2, 16'h0, 1'b0});
    run_op(0, 1'b1, 2'b11, 11'o1234, 16'o52525, lat, rd, wl);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, e.lat); end
    checks++;
    if (wl !== e.wlow) begin failures++; $display("FAIL wr_pulse_width got=%0d exp=%0d", wl, e.wlow); end
    checks++;
    if (A0 !== 16'o1234) begin failures++; $display("FAIL wr_addr_pins got=%o exp=%o", A0, 16'o1234); end
    sb.push_back('{3, 0, 16'o52525, 1'b1});
    run_op(0, 1'b0, 2'b11, 11'o1234, 16'h0, lat, rd, wl);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", lat, e.lat); end
    checks++;
    if (rd !== e.data) begin failures++; $display("FAIL rd_data got=%o exp=%o", rd, e.data); end
  endtask

  task automatic test_byte_mask();
    exp_t e; int lat, wl; logic [15:0] rd;
    sb.push_back('{5, 2, 16'h0, 1'b0});
    sb.push_back('{5, 2, 16'h0, 1'b0});
    sb.push_back('{5, 2, 16'h0, 1'b0});
    sb.push_back('{3, 0, 16'hFF00, 1'b1});
    run_op(0, 1'b1, 2'b11, 11'd5, 16'o177777, lat, rd, wl);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL mask_full_latency got=%0d exp=%0d", lat, e.lat); end
    run_op(0, 1'b1, 2'b01, 11'd5, 16'h0000, lat, rd, wl);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL mask_low_latency got=%0d exp=%0d", lat, e.lat); end
    run_op(0, 1'b1, 2'b00, 11'd5, 16'h1234, lat, rd, wl);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL mask_none_latency got=%0d exp=%0d", lat, e.lat); end
    run_op(0, 1'b0, 2'b11, 11'd5, 16'h0, lat, rd, wl);
    e = sb.pop_front();
    checks++;
    if (rd !== e.data) begin failures++; $display("FAIL mask_rdata got=%h exp=%h", rd, e.data); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat, wl; logic [15:0] rd;
    logic busy6;
    busy6 = 1'b1;
    sb.push_back('{5, 0, 16'h0, 1'b0});
    sb.push_back('{11, 0, 16'h0, 1'b0});
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 2'b11, 11'd7, 16'h1234);
    @(posedge clk);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 1) drive(0, 1'b1, 1'b1, 2'b11, 11'd8, 16'hBEEF);
      if (n == 6) busy6 = bus0.busy;
      if (n == 7) drive(0, 1'b0, 1'b0, 2'b00, 11'd0, 16'h0);
      if (bus0.done) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL b2b_done_cycle got=%0d exp=none", n);
        end else begin
          e = sb.pop_front();
          if (n !== e.lat) begin failures++; $display("FAIL b2b_done_cycle got=%0d exp=%0d", n, e.lat); end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL b2b_missing_done got=%0d exp=0", sb.size()); end
    sb.delete();
    checks++;
    if (busy6 !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b exp=0", busy6); end
    sb.push_back('{3, 0, 16'h1234, 1'b1});
    sb.push_back('{3, 0, 16'hBEEF, 1'b1});
    run_op(0, 1'b0, 2'b11, 11'd7, 16'h0, lat, rd, wl);
    e = sb.pop_front();
    checks++;
    if (rd !== e.data) begin failures++; $display("FAIL b2b_first_data got=%h exp=%h", rd, e.data); end
    run_op(0, 1'b0, 2'b11, 11'd8, 16'h0, lat, rd, wl);
    e = sb.pop_front();
    checks++;
    if (rd !== e.data) begin failures++; $display("FAIL b2b_second_data got=%h exp=%h", rd, e.data); end
  endtask

  task automatic test_reset_mid_pulse();
    exp_t e; int lat, wl; logic [15:0] rd;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 2'b11, 11'd9, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 2'b11, 11'd9, 16'h0000);
    @(negedge clk);
    checks++;
    if (W0_ !== 1'b0) begin failures++; $display("FAIL midrst_pulse_active got=%b exp=0", W0_); end
    rst = 1'b1;
    #1;
    checks++;
    if ({E0_, W0_} !== 2'b11) begin failures++; $display("FAIL midrst_strobes got=%b exp=11", {E0_, W0_}); end
    checks++;
    if (DQ0 !== 16'hFFFF) begin failures++; $display("FAIL midrst_dq got=%h exp=FFFF(pulled)", DQ0); end
    checks++;
    if (bus0.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus0.busy); end
    checks++;
    if (bus0.rdata !== 16'h0000) begin failures++; $display("FAIL midrst_rdata got=%h exp=0000", bus0.rdata); end
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{3, 0, 16'hFF00, 1'b1});
    run_op(0, 1'b0, 2'b11, 11'd5, 16'h0, lat, rd, wl);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL midrst_read_latency got=%0d exp=%0d", lat, e.lat); end
    checks++;
    if (rd !== e.data) begin failures++; $display("FAIL midrst_read_data got=%h exp=%h", rd, e.data); end
  endtask

  task automatic test_param_sweep();
    exp_t e; int lat, wl; logic [15:0] rd;
    sb.push_back('{6, 1, 16'h0, 1'b0});
    run_op(1, 1'b1, 2'b11, 11'd3, 16'hA5C3, lat, rd, wl);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL sweep_wr_latency got=%0d exp=%0d", lat, e.lat); end
    checks++;
    if (wl !== e.wlow) begin failures++; $display("FAIL sweep_pulse_width got=%0d exp=%0d", wl, e.wlow); end
    sb.push_back('{5, 0, 16'hA5C3, 1'b1});
    run_op(1, 1'b0, 2'b11, 11'd3, 16'h0, lat, rd, wl);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL sweep_rd_latency got=%0d exp=%0d", lat, e.lat); end
    checks++;
    if (rd !== e.data) begin failures++; $display("FAIL sweep_rd_data got=%h exp=%h", rd, e.data); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem0[i] = 16'o40000;
      mem1[i] = 16'o40000;
    end
    test_reset();
    test_untouched();
    test_write_read();
    test_byte_mask();
    test_back_to_back();
    test_reset_mid_pulse();
    test_param_sweep();
    checks++;
    if (overlap !== 0) begin failures++; $display("FAIL g_w_overlap got=%0d exp=0", overlap); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/erasable_ram_ctrl.md
# erasable_ram_ctrl

Synchronous sequencer that turns single-word read/write requests from the erasable-memory interface into correctly timed strobe sequences for the asynchronous 2048×16 erasable RAM. It owns the RAM's chip-enable, write-enable, output-enable, byte-enable, address and bidirectional data pins. It guarantees output-enable and write-enable are never low together. It also enforces data setup and hold around the write pulse and bus turnaround after reads.

## Interface
- SETUP_CYC, 1, cycles address/data are stable with E_ low before W_ falls (≥1)
- PULSE_CYC, 2, cycles W_ is held low (≥1)
- READ_CYC, 2, cycles E_ and G_ are held low before data capture (≥1)

- SIM_CLK  in  1  clock; all state changes on rising edge
- SIM_RST  in  1  reset, asynchronous, active-high
- req  in  1  request strobe; sampled only when busy=0
- we  in  1  1=write, 0=read; sampled with req
- be  in  2  byte enables, be[1]=upper (bits 15:8), be[0]=lower (bits 7:0); active-high
- addr  in  11  word address
- wdata  in  16  write data
- busy  out  1  high from the cycle after acceptance through RECOVER
- done  out  1  one-cycle completion pulse
- rdata  out  16  last read word; held until the next read completes
- E_, W_, G_, UB_, LB_  out  1 each  RAM strobes, active-low
- A  out  16  RAM address; A[10:0]=latched addr, A[15:11]=0
- DQ  inout  16  RAM data; driven only in write states, otherwise high-Z

## Operation
- All inputs are latched at acceptance: req=1 and busy=0 on a rising edge. req while busy=1 is ignored; there is no queue.
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_READ, RECOVER.
- IDLE: all strobes high, DQ high-Z. Acceptance goes to W_SETUP if we=1, else to R_READ.
- W_SETUP, SETUP_CYC cycles: E_=0, W_=1, G_=1, UB_=~be[1], LB_=~be[0], DQ=wdata.
- W_PULSE, PULSE_CYC cycles: as W_SETUP but W_=0.
- W_HOLD, 1 cycle: W_=1, E_=0, DQ still driven.
- Then RECOVER.
- R_READ, READ_CYC cycles: E_=0, G_=0, W_=1, byte enables as latched, DQ high-Z. rdata <= DQ on the edge leaving R_READ. Then RECOVER.
- RECOVER, 1 cycle: all strobes high, DQ high-Z, busy=1, done=1. Then IDLE.
- be=2'b00 still runs the full sequence with both byte strobes high; the RAM is untouched and done pulses.
- G_ is forced high in every write state. W_ is forced high in every read state. This is invariant in all cases.
- Internal cycle counter width is sized to the largest parameter.
- Parameter values <1 are illegal and rejected at elaboration.

## Timing
- Reset (asynchronous, immediate) sets E_=W_=G_=UB_=LB_=1, A=0, DQ high-Z, busy=0, done=0, rdata=0, state IDLE.
- Reset mid-write releases W_ and DQ at once; the target word's content is undefined. Reset mid-read discards the read and leaves rdata=0.
- Let e0 be the acceptance edge. Strobes change on e0 itself.
- Write: done is high in cycle SETUP_CYC+PULSE_CYC+2 after e0. This is 5 with defaults.
- Read: done is high in cycle READ_CYC+1 after e0. This is 3 with defaults. rdata is valid from the done cycle.
- A and byte enables are stable from e0 until leaving the last E_-low state.
- DQ is driven at least SETUP_CYC cycles before W_ falls and 1 cycle after W_ rises.
- After a read there is ≥1 cycle with G_ high and DQ high-Z before any write drives DQ (RECOVER).
- busy falls in IDLE. A req present in that first IDLE cycle is accepted on the next edge. Minimum request spacing is therefore latency+1 cycles.

## Test plan
- Write then read: write addr=0o1234, wdata=0o52525, be=11, then read 0o1234. Required: rdata=0o52525, done 5 and 3 cycles after acceptance, W_ low exactly 2 cycles.
- Untouched location: read addr=0o3777 after power-up. Required: rdata=0o40000 (RAM init value).
- Byte masking: write 0o177777 to addr 5, then write 0 with be=01, then read addr 5. Required: upper byte 0xFF00 retained, lower byte 0.
- Busy rejection: assert req every cycle during a write. Required: only the first request accepted, second sequence starts after RECOVER, and G_/W_ never both low (monitor).
- Reset mid-pulse: assert SIM_RST while W_=0. Required: W_, E_ high and DQ high-Z within the same time step, busy=0, rdata=0; a subsequent read completes normally.
- Parameter sweep: SETUP_CYC=3, PULSE_CYC=1, READ_CYC=4. Required: write done at cycle 6, read done at cycle 5, data correct.
